y_buf_argmax_reader: RTL and testbench

Y_BUF_ARGMAX_READER -- requirements
Module: y_buf_argmax_reader

---
 rtl/y_buf_argmax_reader.sv | 170 +++++++++++++++++
 tb/tb_y_buf_argmax_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/y_buf_argmax_reader.sv
// Reads ten signed logits per image from the output buffer, finds the argmax,
// and hands one (image, class, score) result per image to a valid/ready consumer.
module y_buf_argmax_reader #(
    parameter int unsigned IN_IMG_NUM       = 10,
    parameter int unsigned Y_BUF_DATA_WIDTH = 32,
    parameter int unsigned Y_BUF_ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          y_buf_en,
    output logic                          y_buf_wr_en,
    output logic [Y_BUF_ADDR_WIDTH-1:0]   y_buf_addr,
    input  logic [Y_BUF_DATA_WIDTH-1:0]   y_buf_rdata,
    output logic                          cls_valid_o,
    input  logic                          cls_ready_i,
    output logic [$clog2(IN_IMG_NUM)-1:0] cls_img_o,
    output logic [3:0]                    cls_class_o,
    output logic [Y_BUF_DATA_WIDTH-1:0]   cls_score_o
);

    localparam int unsigned IMG_W      = $clog2(IN_IMG_NUM);
    localparam int unsigned AW         = Y_BUF_ADDR_WIDTH;
    localparam int unsigned DW         = Y_BUF_DATA_WIDTH;
    localparam logic [3:0]  N_LOGITS   = 4'd10;
    localparam logic [3:0]  LAST_LOGIT = 4'd9;
    localparam logic [IMG_W-1:0] LAST_IMG = IMG_W'(IN_IMG_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [3:0]             issue_cnt_q;   // next logit index to issue
    logic [3:0]             smp_cnt_q;     // logit index of the next returning word
    logic                   rd_vld_q;      // buffer data is valid this cycle
    logic [IMG_W-1:0]       img_q;
    logic [AW-1:0]          nxt_addr_q;    // images are contiguous, so the address just keeps counting
    logic signed [DW-1:0]   max_q;
    logic [3:0]             cls_q;

    logic                   start_img;
    logic                   issue;
    logic                   last_smp;
    logic                   handshake;
    logic                   take;
    logic signed [DW-1:0]   rdata_s;
    logic [AW-1:0]          issue_addr;

    // The buffer is read-only from this block
    assign y_buf_wr_en = 1'b0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle strobes for the datapath
    always_comb begin
        state_d    = state_q;
        start_img  = 1'b0;
        issue      = 1'b0;
        last_smp   = 1'b0;
        handshake  = 1'b0;
        rdata_s    = y_buf_rdata;
        take       = (smp_cnt_q == 4'd0) || (rdata_s > max_q);
        issue_addr = (state_q == S_IDLE) ? '0 : nxt_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_RD;
                    start_img = 1'b1;
                end
            end
            S_RD: begin
                issue = (issue_cnt_q < N_LOGITS);
                if (rd_vld_q && (smp_cnt_q == LAST_LOGIT)) begin
                    last_smp = 1'b1;
                    state_d  = S_OUT;
                end
            end
            S_OUT: begin
                handshake = cls_valid_o && cls_ready_i;
                if (handshake) begin
                    if (img_q == LAST_IMG) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_RD;
                        start_img = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read issue, return tracking, running argmax and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            y_buf_en    <= 1'b0;
            y_buf_addr  <= '0;
            nxt_addr_q  <= '0;
            issue_cnt_q <= '0;
            smp_cnt_q   <= '0;
            rd_vld_q    <= 1'b0;
            img_q       <= '0;
            max_q       <= '0;
            cls_q       <= '0;
            cls_valid_o <= 1'b0;
            cls_img_o   <= '0;
            cls_class_o <= '0;
            cls_score_o <= '0;
        end else begin
            busy_o   <= (state_d != S_IDLE);
            done_o   <= (state_d == S_DONE);
            y_buf_en <= start_img | issue;
            rd_vld_q <= y_buf_en;

            if (start_img || issue) begin
                y_buf_addr <= issue_addr;
                nxt_addr_q <= issue_addr + AW'(4);
            end

            if (start_img) begin
                issue_cnt_q <= 4'd1;
            end else if (issue) begin
                issue_cnt_q <= issue_cnt_q + 4'd1;
            end

            if (start_img) begin
                smp_cnt_q <= '0;
            end else if (rd_vld_q) begin
                smp_cnt_q <= smp_cnt_q + 4'd1;
            end

            if (start_img) begin
                img_q <= (state_q == S_IDLE) ? '0 : img_q + IMG_W'(1);
            end

            if ((state_q == S_RD) && rd_vld_q && take) begin
                max_q <= rdata_s;
                cls_q <= smp_cnt_q;
            end

            if (last_smp) begin
                cls_valid_o <= 1'b1;
                cls_img_o   <= img_q;
                cls_class_o <= take ? smp_cnt_q : cls_q;
                cls_score_o <= take ? rdata_s : max_q;
            end else if (handshake) begin
                cls_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_y_buf_argmax_reader.sv
// Directed bench: BRAM model behind the buffer port, expected results queued
// per run and popped as each classification appears.
module tb_y_buf_argmax_reader;

    localparam int unsigned N_IMG = 10;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        y_buf_en;
    logic        y_buf_wr_en;
    logic [31:0] y_buf_addr;
    logic [31:0] y_buf_rdata;
    logic        cls_valid_o;
    logic        cls_ready_i;
    logic [3:0]  cls_img_o;
    logic [3:0]  cls_class_o;
    logic [31:0] cls_score_o;

    typedef struct {
        int          img;
        int          cls;
        logic [31:0] score;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:N_IMG*10-1];
    int          checks = 0;
    int          errors = 0;

    y_buf_argmax_reader #(
        .IN_IMG_NUM      (N_IMG),
        .Y_BUF_DATA_WIDTH(32),
        .Y_BUF_ADDR_WIDTH(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .y_buf_en   (y_buf_en),
        .y_buf_wr_en(y_buf_wr_en),
        .y_buf_addr (y_buf_addr),
        .y_buf_rdata(y_buf_rdata),
        .cls_valid_o(cls_valid_o),
        .cls_ready_i(cls_ready_i),
        .cls_img_o  (cls_img_o),
        .cls_class_o(cls_class_o),
        .cls_score_o(cls_score_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM, one-cycle read latency
    always @(posedge clk) begin
        if (y_buf_en && !y_buf_wr_en) begin
            if (int'(y_buf_addr >> 2) < int'(N_IMG * 10))
                y_buf_rdata <= mem[int'(y_buf_addr >> 2)];
            else
                y_buf_rdata <= 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_main();
        for (int i = 0; i < int'(N_IMG); i++)
            for (int k = 0; k < 10; k++)
                mem[i*10+k] = (k == i % 10) ? 32'(500 + i) : 32'(-100 + k);
    endtask

    task automatic push_main(input int first);
        exp_t x;
        for (int i = first; i < int'(N_IMG); i++) begin
            x.img = i; x.cls = i % 10; x.score = 32'(500 + i);
            sb.push_back(x);
        end
    endtask

    task automatic push_one(input int img, input int cls, input logic [31:0] score);
        exp_t x;
        x.img = img; x.cls = cls; x.score = score;
        sb.push_back(x);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  64'(busy_o), 0);
        chk({tag, "_done"},  64'(done_o), 0);
        chk({tag, "_en"},    64'(y_buf_en), 0);
        chk({tag, "_wr_en"}, 64'(y_buf_wr_en), 0);
        chk({tag, "_addr"},  64'(y_buf_addr), 0);
        chk({tag, "_valid"}, 64'(cls_valid_o), 0);
        chk({tag, "_img"},   64'(cls_img_o), 0);
        chk({tag, "_class"}, 64'(cls_class_o), 0);
        chk({tag, "_score"}, 64'(cls_score_o), 0);
    endtask

    // One full readout; optional consumer stall on image 0, stray start pulse, or reset abort
    task automatic run_seq(input int stall, input int inj_img, input int abort_img, input int abort_e);
        int   e;
        exp_t x;
        cls_ready_i = (stall == 0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int j = 0; j < int'(N_IMG); j++) begin
            e = 0;
            chk("busy_rd", 64'(busy_o), 1);
            while (cls_valid_o !== 1'b1 && e < 20) begin
                if (e <= 9) begin
                    chk("rd_en", 64'(y_buf_en), 1);
                    chk("rd_addr", 64'(y_buf_addr), 64'((j*10 + e) * 4));
                end else begin
                    chk("rd_en_off", 64'(y_buf_en), 0);
                end
                if (j == abort_img && e == abort_e) begin
                    rst_n = 1'b0;
                    #1;
                    chk_all_zero("abort");
                    #1;
                    rst_n = 1'b1;
                    sb.delete();
                    return;
                end
                start_i = (j == inj_img && e == 3);
                step();
                e++;
            end
            start_i = 1'b0;
            chk("valid_edge", 64'(e), 11);
            chk("en_in_out", 64'(y_buf_en), 0);
            if (sb.size() == 0) begin
                chk("sb_nonempty", 0, 1);
                x.img = -1; x.cls = -1; x.score = 'x;
            end else begin
                x = sb.pop_front();
            end
            chk("cls_img", 64'(cls_img_o), 64'(x.img));
            chk("cls_class", 64'(cls_class_o), 64'(x.cls));
            chk("cls_score", 64'(cls_score_o), 64'(x.score));
            if (j == 0 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    step();
                    chk("stall_valid", 64'(cls_valid_o), 1);
                    chk("stall_img", 64'(cls_img_o), 64'(x.img));
                    chk("stall_class", 64'(cls_class_o), 64'(x.cls));
                    chk("stall_score", 64'(cls_score_o), 64'(x.score));
                    chk("stall_en", 64'(y_buf_en), 0);
                end
                cls_ready_i = 1'b1;
            end
            step();
            chk("valid_drop", 64'(cls_valid_o), 0);
        end
        chk("done_pulse", 64'(done_o), 1);
        chk("busy_done", 64'(busy_o), 1);
        step();
        chk("done_low", 64'(done_o), 0);
        chk("busy_idle", 64'(busy_o), 0);
        for (int s = 0; s < 5; s++) begin
            step();
            chk("idle_valid", 64'(cls_valid_o), 0);
            chk("idle_done", 64'(done_o), 0);
        end
        chk("sb_empty", 64'(sb.size()), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        cls_ready_i = 1'b0;
        y_buf_rdata = '0;
        fill_main();
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk("idle_busy", 64'(busy_o), 0);

        // Main pattern, ready always high, stray start during image 4
        push_main(0);
        run_seq(0, 4, -1, -1);

        // All-equal logits on image 0, consumer stalls 20 cycles on the first result
        for (int k = 0; k < 10; k++) mem[k] = 32'd7;
        push_one(0, 0, 32'd7);
        push_main(1);
        run_seq(20, -1, -1, -1);

        // Signed comparison: most-negative everywhere except -1 at logit 9
        for (int k = 0; k < 10; k++) mem[k] = 32'h8000_0000;
        mem[9] = 32'hFFFF_FFFF;
        push_one(0, 9, 32'hFFFF_FFFF);
        push_main(1);
        run_seq(0, -1, -1, -1);

        // Largest positive value at logit 3 wins over -1
        mem[3] = 32'h7FFF_FFFF;
        push_one(0, 3, 32'h7FFF_FFFF);
        push_main(1);
        run_seq(0, -1, -1, -1);

        // Reset abort at E5 of image 2, then a clean restart from image 0
        fill_main();
        push_main(0);
        run_seq(0, -1, 2, 5);
        for (int s = 0; s < 30; s++) begin
            step();
            chk("post_abort_busy", 64'(busy_o), 0);
            chk("post_abort_valid", 64'(cls_valid_o), 0);
            chk("post_abort_done", 64'(done_o), 0);
            chk("post_abort_en", 64'(y_buf_en), 0);
        end
        push_main(0);
        run_seq(0, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
